// File: rtl/decode_execute_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : decode_execute_pipe_reg
// Brief   : ID->EX pipeline register with valid/ready handshake, stall, flush,
//           bubble insertion and a saturating stall counter. Define SKID_EN to
//           add a one-entry skid buffer that registers id_ready.
// Revision: 1.0 - initial release
// ============================================================================
module decode_execute_pipe_reg #(
    parameter int CTRL_W      = 20,
    parameter int DATA_W      = 133,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [CTRL_W-1:0]      id_ctrl,
    input  logic [DATA_W-1:0]      id_data,
    input  logic                   flush,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic [DATA_W-1:0]      ex_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   r_ex_valid;
    logic [CTRL_W-1:0]      r_ex_ctrl;
    logic [DATA_W-1:0]      r_ex_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_slot_free;
    logic w_accept;
    logic w_stalled;
    logic w_skid_load;

    assign w_slot_free = !r_ex_valid || ex_ready;
    assign w_stalled   = r_ex_valid && !ex_ready;
    assign w_accept    = id_valid && id_ready;

`ifdef SKID_EN
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    // Ready comes straight from a flop, so ex_ready never reaches decode.
    assign id_ready    = !r_skid_valid;
    assign w_skid_load = r_skid_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (w_slot_free && r_skid_valid) begin
            r_skid_valid <= 1'b0;
        end else if (!w_slot_free && w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= id_ctrl;
            r_skid_data  <= id_data;
        end
    end
`else
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    assign id_ready    = w_slot_free;
    assign w_skid_load = 1'b0;
    assign r_skid_ctrl = '0;
    assign r_skid_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_data  <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (w_slot_free) begin
            if (w_skid_load) begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= r_skid_ctrl;
                r_ex_data  <= r_skid_data;
            end else if (w_accept) begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= id_ctrl;
                r_ex_data  <= id_data;
            end else begin
                // Bubble: data is left as-is, only control is cleared.
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_ctrl   = r_ex_ctrl;
    assign ex_data   = r_ex_data;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_execute_pipe_reg
// Brief   : Directed self-checking bench for decode_execute_pipe_reg; builds
//           with or without SKID_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decode_execute_pipe_reg;

    localparam int CTRL_W      = 20;
    localparam int DATA_W      = 133;
    localparam int STALL_CNT_W = 4;

    logic                   clk;
    logic                   reset;
    logic                   id_valid;
    logic                   id_ready;
    logic [CTRL_W-1:0]      id_ctrl;
    logic [DATA_W-1:0]      id_data;
    logic                   flush;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [CTRL_W-1:0]      ex_ctrl;
    logic [DATA_W-1:0]      ex_data;
    logic [STALL_CNT_W-1:0] stall_cnt;

    int  n_checks;
    int  n_pass;
    logic r_acc;
    logic b_taken;

    decode_execute_pipe_reg #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_ctrl   (id_ctrl),
        .id_data   (id_data),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_ctrl   (ex_ctrl),
        .ex_data   (ex_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Control pattern tied to the data value; top bit set so it is never zero.
    function automatic logic [CTRL_W-1:0] ctrl_of(input int v);
        return CTRL_W'(v) | 20'h80000;
    endfunction

    task automatic tick();
        r_acc = id_valid && id_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int v);
        id_valid = 1'b1;
        id_data  = DATA_W'(v);
        id_ctrl  = ctrl_of(v);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        id_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        id_ctrl  = '0;
        id_data  = '0;
        flush    = 1'b0;
        ex_ready = 1'b1;

        // 1: reset with id_valid asserted
        reset = 1'b1;
        offer(32'h55);
        tick();
        tick();
        chk("rst_valid", DATA_W'(ex_valid), DATA_W'(0));
        chk("rst_ctrl", DATA_W'(ex_ctrl), DATA_W'(0));
        chk("rst_data", ex_data, DATA_W'(0));
        chk("rst_cnt", DATA_W'(stall_cnt), DATA_W'(0));
        reset    = 1'b0;
        id_valid = 1'b0;
        tick();

        // 2: eight-beat stream, no gaps
        ex_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i);
            tick();
            chk($sformatf("strm_v%0d", i), DATA_W'(ex_valid), DATA_W'(1));
            chk($sformatf("strm_d%0d", i), ex_data, DATA_W'(i));
        end
        chk("strm_ctrl8", DATA_W'(ex_ctrl), DATA_W'(ctrl_of(8)));

        // 3: five-cycle stall of A with B waiting
        do_reset();
        ex_ready = 1'b0;
        offer(32'hA0);
        tick();
        chk("stl_a_v", DATA_W'(ex_valid), DATA_W'(1));
        b_taken = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            offer(32'hB0);
            id_valid = !b_taken;
            #1;
`ifdef SKID_EN
            chk($sformatf("stl_rdy%0d", k), DATA_W'(id_ready), DATA_W'(k == 1));
`else
            chk($sformatf("stl_rdy%0d", k), DATA_W'(id_ready), DATA_W'(0));
`endif
            tick();
            if (r_acc) b_taken = 1'b1;
            chk($sformatf("stl_hold%0d", k), ex_data, DATA_W'(32'hA0));
        end
        chk("stl_cnt5", DATA_W'(stall_cnt), DATA_W'(5));
        ex_ready = 1'b1;
        id_valid = !b_taken;
        tick();
        chk("stl_b_v", DATA_W'(ex_valid), DATA_W'(1));
        chk("stl_b_d", ex_data, DATA_W'(32'hB0));
        chk("stl_b_c", DATA_W'(ex_ctrl), DATA_W'(ctrl_of(32'hB0)));
        id_valid = 1'b0;
        tick();
        chk("stl_nodup", DATA_W'(ex_valid), DATA_W'(0));
        chk("stl_cnt_keep", DATA_W'(stall_cnt), DATA_W'(5));

        // 4: flush with output pending (and skid full when present)
        do_reset();
        ex_ready = 1'b0;
        offer(32'hA1);
        tick();
        offer(32'hB1);
        tick();
        offer(32'hD1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        id_valid = 1'b0;
        chk("fl_valid", DATA_W'(ex_valid), DATA_W'(0));
        chk("fl_ctrl", DATA_W'(ex_ctrl), DATA_W'(0));
        chk("fl_data", ex_data, DATA_W'(32'hA1));
        chk("fl_cnt", DATA_W'(stall_cnt), DATA_W'(2));
        #1;
        chk("fl_rdy", DATA_W'(id_ready), DATA_W'(1));
        ex_ready = 1'b1;
        offer(32'hC1);
        tick();
        chk("fl_c_v", DATA_W'(ex_valid), DATA_W'(1));
        chk("fl_c_d", ex_data, DATA_W'(32'hC1));
        id_valid = 1'b0;
        tick();
        chk("fl_nostale", DATA_W'(ex_valid), DATA_W'(0));

        // 5: single bubble mid-stream
        do_reset();
        offer(32'h11);
        tick();
        offer(32'h22);
        tick();
        id_valid = 1'b0;
        tick();
        chk("bub_valid", DATA_W'(ex_valid), DATA_W'(0));
        chk("bub_ctrl", DATA_W'(ex_ctrl), DATA_W'(0));
        chk("bub_data", ex_data, DATA_W'(32'h22));
        offer(32'h33);
        tick();
        chk("bub_next", ex_data, DATA_W'(32'h33));
        chk("bub_next_v", DATA_W'(ex_valid), DATA_W'(1));

        // 6: counter saturation at 15
        do_reset();
        ex_ready = 1'b0;
        offer(32'h66);
        tick();
        id_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) chk("sat_cnt14", DATA_W'(stall_cnt), DATA_W'(14));
        end
        chk("sat_cnt20", DATA_W'(stall_cnt), DATA_W'(15));
        tick();
        tick();
        tick();
        chk("sat_hold", DATA_W'(stall_cnt), DATA_W'(15));
        chk("sat_data", ex_data, DATA_W'(32'h66));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
